vga_capture: RTL and testbench
==============================

# vga_capture

Sink-side VGA timing receiver. It samples an 8-bit RGB332 pixel bus plus Hsync/Vsync on a pixel-rate strobe and recovers horizontal and vertical counters. It locks onto a fixed video mode and emits pixel coordinates and data for active-area pixels. It sits at the far end of the VGA output path and serves as the self-checking receiver in the `top` loopback simulation and as the on-board capture front end.

## Interface
- H_ACT, 640, active pixels per line
- H_SYNC, 96, Hsync pulse width in pixels
- H_BP, 48, back porch in pixels
- H_TOTAL, 800, pixels per line
- V_ACT, 480, active lines per frame
- V_SYNC, 2, Vsync pulse width in lines
- V_BP, 33, back porch in lines
- V_TOTAL, 525, lines per frame
- SYNC_POL, 0, asserted level of Hsync/Vsync (0 = active-low)
- LOCK_FRAMES, 2, consecutive good frames required to lock (1..15)

Ports (`pix_en`, `hsync_in`, `vsync_in` and `rgb_in` are synchronous to `clk`):
- clk  in  1  system clock (50 MHz)
- rst_n  in  1  asynchronous active-low reset
- pix_en  in  1  pixel strobe, one cycle per pixel (25 MHz rate)
- hsync_in  in  1  Hsync
- vsync_in  in  1  Vsync
- rgb_in  in  8  pixel, {R[2:0],G[2:0],B[1:0]}
- pix_valid  out  1  one-cycle pulse: active pixel captured
- pix_x  out  10  column of captured pixel
- pix_y  out  10  row of captured pixel
- pix_data  out  8  captured pixel
- frame_start  out  1  pulse coincident with pix_valid at (0,0)
- locked  out  1  mode lock status
- err_cnt  out  8  saturating count of timing errors

## Operation
- All state advances only on cycles with pix_en=1. Each such cycle is a "sample".
- Edge detect: hs_edge is 1 when hsync_in is at SYNC_POL in this sample and was not at SYNC_POL in the previous sample. vs_edge is defined the same way for vsync_in.
- hcnt (11b): set to 0 on hs_edge, otherwise incremented by 1.
- vcnt (10b): set to 0 on vs_edge. Otherwise, on hs_edge, incremented by 1. If vs_edge and hs_edge occur in the same sample, vs_edge wins.
- Active region: hcnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACT-1] and vcnt in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACT-1].
  - x = hcnt-(H_SYNC+H_BP)
  - y = vcnt-(V_SYNC+V_BP)
- Errors are checked on every sample:
  - line_err: hs_edge with the pre-reset hcnt ≠ H_TOTAL-1, or hcnt reaching H_TOTAL with no edge (missing Hsync; hcnt then holds at H_TOTAL until the next hs_edge).
  - frame_err: vs_edge with the pre-reset vcnt ≠ V_TOTAL-1, or vcnt reaching V_TOTAL (vcnt holds at V_TOTAL).
  - The first vs_edge after leaving SEARCH does not check frame length.
- FSM:
  - SEARCH: entered from reset. Go to TRACK on the first vs_edge, with good_cnt=0.
  - TRACK: any error sets good_cnt=0. An error-free frame ending at vs_edge increments good_cnt. When good_cnt reaches LOCK_FRAMES, go to LOCKED.
  - LOCKED: any error goes to SEARCH.
- locked=1 only in LOCKED.
- pix_valid, pix_x, pix_y, pix_data and frame_start are produced only while in LOCKED and the sample is in the active region.
- err_cnt increments on each sample that has line_err or frame_err; one sample counts +1 even if both errors occur. It saturates at 255. It is only cleared by reset.

## Timing
- Reset values:
  - FSM=SEARCH, hcnt=0, vcnt=0.
  - Previous-sample sync registers hold the deasserted level.
  - All outputs are 0.
- Latency: a sample at rising edge N drives pix_valid/pix_x/pix_y/pix_data/frame_start in cycle N+1.
- pix_valid and frame_start are exactly 1 clk wide. pix_x, pix_y and pix_data hold until the next pix_valid.
- locked:
  - Rises in the cycle after the vs_edge sample that completes the LOCK_FRAMES-th good frame.
  - Falls in the cycle after the erroring sample.
  - No pix_valid is produced for the erroring sample.
- err_cnt updates in the cycle after the erroring sample.
- pix_en=0 freezes all state. The pix_en spacing is irrelevant to the logic.
- Asynchronous reset mid-frame clears everything immediately. A new lock needs 1 vs_edge plus LOCK_FRAMES good frames.

## Test plan
- Nominal 640x480 stream, pix_en every 2nd clk, rgb_in=x[7:0]^y[7:0], LOCK_FRAMES=2 -> locked rises after the 3rd vs_edge.
  - Frame 4 yields exactly 307200 pix_valid pulses with matching data.
  - frame_start occurs once per frame, at (0,0).
  - err_cnt=0.
- While locked, one 799-pixel line -> locked=0 the cycle after that hs_edge sample and err_cnt=1. Relock occurs after 1+2 further frames.
- Hsync held deasserted for 900 pixels -> line_err at hcnt=800, err_cnt=1, and no further increments until Hsync resumes.
- Vsync and Hsync asserted in the same sample -> vcnt=0. The first active line reports pix_y=0, and there is no spurious frame_err.
- rst_n pulsed low mid-active-line -> all outputs 0 immediately and pix_valid stays silent until the relock condition is met.
- SYNC_POL=1 with inverted syncs -> identical results to the nominal case.

Source files
------------

// File: rtl/vga_capture.sv
// vga_capture: sink-side VGA timing receiver.
// Samples hsync/vsync/rgb on each pix_en strobe, rebuilds the horizontal and
// vertical counters from sync leading edges, locks onto one fixed video mode
// and forwards active-area pixels with their coordinates.
module vga_capture #(
  parameter int   H_ACT       = 640,
  parameter int   H_SYNC      = 96,
  parameter int   H_BP        = 48,
  parameter int   H_TOTAL     = 800,
  parameter int   V_ACT       = 480,
  parameter int   V_SYNC      = 2,
  parameter int   V_BP        = 33,
  parameter int   V_TOTAL     = 525,
  parameter logic SYNC_POL    = 1'b0,
  parameter int   LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_en,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic [7:0] rgb_in,
  output logic       pix_valid,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic [7:0] pix_data,
  output logic       frame_start,
  output logic       locked,
  output logic [7:0] err_cnt
);

  // Counter limits and active window in counter widths
  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_LIM  = 11'(H_TOTAL);
  localparam logic [10:0] H_ST   = 11'(H_SYNC + H_BP);
  localparam logic [10:0] H_END  = 11'(H_SYNC + H_BP + H_ACT - 1);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_LIM  = 10'(V_TOTAL);
  localparam logic [9:0]  V_ST   = 10'(V_SYNC + V_BP);
  localparam logic [9:0]  V_END  = 10'(V_SYNC + V_BP + V_ACT - 1);
  localparam logic [3:0]  LOCK_N = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [3:0]  good_cnt, good_nx;
  logic        dirty, dirty_nx;

  logic        hs_prev, vs_prev;
  logic        hs_now, vs_now;
  logic        hs_edge, vs_edge;

  logic [10:0] hcnt, hcnt_nx;
  logic [9:0]  vcnt, vcnt_nx;
  logic        line_bad, frame_bad;
  logic        checking;
  logic        line_err, frame_err, any_err;

  logic        in_act;
  logic        cap;
  logic [9:0]  cap_x, cap_y;

  // Sync inputs reduced to "asserted" flags so polarity is handled once
  assign hs_now  = (hsync_in == SYNC_POL);
  assign vs_now  = (vsync_in == SYNC_POL);
  assign hs_edge = hs_now & ~hs_prev;
  assign vs_edge = vs_now & ~vs_prev;

  // Previous-sample sync levels, reset to deasserted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_prev <= 1'b0;
      vs_prev <= 1'b0;
    end else if (pix_en) begin
      hs_prev <= hs_now;
      vs_prev <= vs_now;
    end
  end

  // Horizontal counter: restart on hs_edge, saturate at H_TOTAL if Hsync goes missing
  always_comb begin
    hcnt_nx  = hcnt;
    line_bad = 1'b0;
    if (hs_edge) begin
      hcnt_nx  = '0;
      line_bad = (hcnt != H_LAST);
    end else if (hcnt < H_LIM) begin
      hcnt_nx  = hcnt + 11'd1;
      line_bad = (hcnt == H_LAST);
    end
  end

  // Vertical counter: restart on vs_edge (wins over hs_edge), saturate at V_TOTAL
  always_comb begin
    vcnt_nx   = vcnt;
    frame_bad = 1'b0;
    if (vs_edge) begin
      vcnt_nx   = '0;
      frame_bad = (vcnt != V_LAST);
    end else if (hs_edge && (vcnt < V_LIM)) begin
      vcnt_nx   = vcnt + 10'd1;
      frame_bad = (vcnt == V_LAST);
    end
  end

  // While searching the counters have no valid reference yet, so the very
  // first edges after reset or a lost lock are never reported as errors.
  assign checking  = (state != SEARCH);
  assign line_err  = pix_en & checking & line_bad;
  assign frame_err = pix_en & checking & frame_bad;
  assign any_err   = line_err | frame_err;

  // Coordinates of the current sample use the post-update counter values
  assign in_act = (hcnt_nx >= H_ST) && (hcnt_nx <= H_END) &&
                  (vcnt_nx >= V_ST) && (vcnt_nx <= V_END);
  assign cap    = pix_en & (state == LOCKED) & in_act & ~any_err;
  assign cap_x  = 10'(hcnt_nx - H_ST);
  assign cap_y  = vcnt_nx - V_ST;

  // Counter registers advance only on samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (pix_en) begin
      hcnt <= hcnt_nx;
      vcnt <= vcnt_nx;
    end
  end

  // Lock FSM state, good-frame counter and per-frame error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= SEARCH;
      good_cnt <= '0;
      dirty    <= 1'b0;
    end else begin
      state    <= state_nx;
      good_cnt <= good_nx;
      dirty    <= dirty_nx;
    end
  end

  // Lock FSM next state: count error-free frames in TRACK, drop on any error in LOCKED.
  // An error earlier in a frame is remembered in dirty so that frame cannot count as good.
  always_comb begin
    state_nx = state;
    good_nx  = good_cnt;
    dirty_nx = dirty;
    if (pix_en) begin
      case (state)
        SEARCH: begin
          if (vs_edge) begin
            state_nx = TRACK;
            good_nx  = '0;
            dirty_nx = 1'b0;
          end
        end
        TRACK: begin
          if (vs_edge) begin
            dirty_nx = 1'b0;
            if (any_err || dirty) begin
              good_nx = '0;
            end else if ((good_cnt + 4'd1) == LOCK_N) begin
              state_nx = LOCKED;
              good_nx  = '0;
            end else begin
              good_nx = good_cnt + 4'd1;
            end
          end else if (any_err) begin
            good_nx  = '0;
            dirty_nx = 1'b1;
          end
        end
        LOCKED: begin
          if (any_err) begin
            state_nx = SEARCH;
          end
        end
        default: begin
          state_nx = SEARCH;
        end
      endcase
    end
  end

  assign locked = (state == LOCKED);

  // Capture outputs: one-clock pulses, coordinates and data hold until the next capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_valid   <= 1'b0;
      frame_start <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_data    <= '0;
    end else begin
      pix_valid   <= cap;
      frame_start <= cap & (cap_x == 10'd0) & (cap_y == 10'd0);
      if (cap) begin
        pix_x    <= cap_x;
        pix_y    <= cap_y;
        pix_data <= rgb_in;
      end
    end
  end

  // Saturating timing-error counter, one count per erroring sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (any_err && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_vga_capture.sv
// tb_vga_capture: drives a reduced-size video mode into two receivers
// (active-low and active-high sync polarity) and checks captured pixels,
// lock status and error count against a frame/line level model.
module tb_vga_capture;

  localparam int H_ACT = 16, H_SYNC = 4, H_BP = 3, H_TOTAL = 28;
  localparam int V_ACT = 8,  V_SYNC = 2, V_BP = 3, V_TOTAL = 16;
  localparam int LOCKN = 2;
  localparam int H_ST  = H_SYNC + H_BP;
  localparam int V_ST  = V_SYNC + V_BP;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pix_en = 1'b0;
  logic       hs0 = 1'b1, vs0 = 1'b1, hs1 = 1'b0, vs1 = 1'b0;
  logic [7:0] rgb = 8'h00;

  logic       pv0, fs0, lk0, pv1, fs1, lk1;
  logic [9:0] x0, y0, x1, y1;
  logic [7:0] d0, e0, d1, e1;

  always #10 clk = ~clk;

  vga_capture #(
    .H_ACT(H_ACT), .H_SYNC(H_SYNC), .H_BP(H_BP), .H_TOTAL(H_TOTAL),
    .V_ACT(V_ACT), .V_SYNC(V_SYNC), .V_BP(V_BP), .V_TOTAL(V_TOTAL),
    .SYNC_POL(1'b0), .LOCK_FRAMES(LOCKN)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .hsync_in(hs0), .vsync_in(vs0),
    .rgb_in(rgb), .pix_valid(pv0), .pix_x(x0), .pix_y(y0), .pix_data(d0),
    .frame_start(fs0), .locked(lk0), .err_cnt(e0)
  );

  vga_capture #(
    .H_ACT(H_ACT), .H_SYNC(H_SYNC), .H_BP(H_BP), .H_TOTAL(H_TOTAL),
    .V_ACT(V_ACT), .V_SYNC(V_SYNC), .V_BP(V_BP), .V_TOTAL(V_TOTAL),
    .SYNC_POL(1'b1), .LOCK_FRAMES(LOCKN)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .hsync_in(hs1), .vsync_in(vs1),
    .rgb_in(rgb), .pix_valid(pv1), .pix_x(x1), .pix_y(y1), .pix_data(d1),
    .frame_start(fs1), .locked(lk1), .err_cnt(e1)
  );

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [7:0] d;
    logic       fs;
  } px_t;

  px_t         q0[$], q1[$];
  int          bad0 = 0, bad1 = 0, seen0 = 0, seen1 = 0, pushed = 0;
  int          n_chk = 0, n_pass = 0, exp_err = 0, fno = 0;
  logic [27:0] last0 = '0, last1 = '0;
  logic        pvp0 = 1'b0, pvp1 = 1'b0;

  // Pixel monitor for the active-low receiver
  always @(negedge clk) begin : mon0
    px_t e;
    if (!rst_n) begin
      last0 = '0;
    end else if (pv0) begin
      seen0++;
      if (pvp0) bad0++;
      if (q0.size() == 0) bad0++;
      else begin
        e = q0.pop_front();
        if ({x0, y0, d0, fs0} !== e) bad0++;
        last0 = {e.x, e.y, e.d};
      end
    end else if (fs0 !== 1'b0 || {x0, y0, d0} !== last0) begin
      bad0++;
    end
    pvp0 = pv0;
  end

  // Pixel monitor for the active-high receiver
  always @(negedge clk) begin : mon1
    px_t e;
    if (!rst_n) begin
      last1 = '0;
    end else if (pv1) begin
      seen1++;
      if (pvp1) bad1++;
      if (q1.size() == 0) bad1++;
      else begin
        e = q1.pop_front();
        if ({x1, y1, d1, fs1} !== e) bad1++;
        last1 = {e.x, e.y, e.d};
      end
    end else if (fs1 !== 1'b0 || {x1, y1, d1} !== last1) begin
      bad1++;
    end
    pvp1 = pv1;
  end

  // One pixel strobe followed by 'gap' idle clocks with junk on the inputs
  task automatic sample(input logic hs, input logic vs, input logic [7:0] px, input int gap);
    pix_en = 1'b1;
    hs1 = hs;  vs1 = vs;
    hs0 = ~hs; vs0 = ~vs;
    rgb = px;
    @(posedge clk); #1;
    pix_en = 1'b0;
    for (int i = 0; i < gap; i++) begin
      hs0 = 1'($urandom); vs0 = 1'($urandom);
      hs1 = 1'($urandom); vs1 = 1'($urandom);
      rgb = 8'($urandom);
      @(posedge clk); #1;
    end
  endtask

  // One frame starting with the vsync line; kind: 0 clean, 1 short line,
  // 2 missing hsync on line bl, 3 reset pulse in the middle of line bl
  task automatic send_frame(input bit exp_pre, input bit exp_post, input int kind,
                            input int bl, input bit xor_rgb, input int gmax);
    bit         px_on, act, exp_end;
    int         len, xx, yy;
    logic [7:0] px;
    px_t        e;
    px_on = exp_post;
    n_chk++;
    if (lk0 !== exp_pre || lk1 !== exp_pre)
      $display("FAIL locked_pre frame=%0d: got %b/%b required %b", fno, lk0, lk1, exp_pre);
    else n_pass++;
    for (int l = 0; l < V_TOTAL; l++) begin
      len = H_TOTAL;
      if (kind == 1 && l == bl) len = H_TOTAL - 1;
      if (kind == 2 && l == bl) len = H_TOTAL + 12;
      if ((kind == 1 || kind == 2) && l > bl) px_on = 1'b0;
      for (int p = 0; p < len; p++) begin
        xx  = p - H_ST;
        yy  = l - V_ST;
        act = (xx >= 0) && (xx < H_ACT) && (yy >= 0) && (yy < V_ACT);
        px  = (act && xor_rgb) ? 8'(xx ^ yy) : 8'($urandom);
        if (kind == 3 && l == bl && p == H_ST + 5) begin
          #2 rst_n = 1'b0;
          #1;
          n_chk++;
          if ({pv0, fs0, lk0, x0, y0, d0, e0} !== '0 || {pv1, fs1, lk1, x1, y1, d1, e1} !== '0)
            $display("FAIL reset_mid: dut0 v=%b fs=%b lk=%b x=%0d y=%0d d=%h e=%0d dut1 v=%b fs=%b lk=%b x=%0d y=%0d d=%h e=%0d required all 0",
                     pv0, fs0, lk0, x0, y0, d0, e0, pv1, fs1, lk1, x1, y1, d1, e1);
          else n_pass++;
          @(posedge clk); #1 rst_n = 1'b1;
          px_on   = 1'b0;
          exp_err = 0;
        end
        if (kind == 1 && l == bl + 1 && p == 0) exp_err++;
        if (kind == 2 && l == bl && p == H_TOTAL) exp_err++;
        if (px_on && act) begin
          e.x = 10'(xx); e.y = 10'(yy); e.d = px; e.fs = (xx == 0 && yy == 0);
          q0.push_back(e);
          q1.push_back(e);
          pushed++;
        end
        sample(p < H_SYNC, l < V_SYNC, px, (gmax <= 1) ? 1 : int'($urandom_range(gmax, 1)));
        if (l == 0 && p == 0) begin
          n_chk++;
          if (lk0 !== exp_post || lk1 !== exp_post)
            $display("FAIL locked_after_vs frame=%0d: got %b/%b required %b", fno, lk0, lk1, exp_post);
          else n_pass++;
        end
        if ((kind == 1 && ((l == bl && p == len - 1) || (l == bl + 1 && p == 0))) ||
            (kind == 2 && l == bl && (p == H_TOTAL - 1 || p == H_TOTAL || p == len - 1))) begin
          n_chk++;
          if (lk0 !== (l == bl && p < H_TOTAL) || lk1 !== (l == bl && p < H_TOTAL) ||
              e0 !== 8'(exp_err) || e1 !== 8'(exp_err))
            $display("FAIL line_err kind=%0d l=%0d p=%0d: locked %b/%b err %0d/%0d required locked %b err %0d",
                     kind, l, p, lk0, lk1, e0, e1, (l == bl && p < H_TOTAL), exp_err);
          else n_pass++;
        end
      end
    end
    n_chk++;
    if (q0.size() != 0 || q1.size() != 0 || bad0 != 0 || bad1 != 0)
      $display("FAIL pixels frame=%0d: pending %0d/%0d mismatches %0d/%0d required 0", fno, q0.size(), q1.size(), bad0, bad1);
    else n_pass++;
    bad0 = 0; bad1 = 0;
    q0.delete(); q1.delete();
    n_chk++;
    if (e0 !== 8'(exp_err) || e1 !== 8'(exp_err))
      $display("FAIL err_cnt frame=%0d: got %0d/%0d required %0d", fno, e0, e1, exp_err);
    else n_pass++;
    exp_end = (kind != 0) ? 1'b0 : exp_post;
    n_chk++;
    if (lk0 !== exp_end || lk1 !== exp_end)
      $display("FAIL locked_end frame=%0d: got %b/%b required %b", fno, lk0, lk1, exp_end);
    else n_pass++;
    fno++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if ({pv0, fs0, lk0, x0, y0, d0, e0} !== '0 || {pv1, fs1, lk1, x1, y1, d1, e1} !== '0)
      $display("FAIL reset_state: dut0 %b%b%b %0d %0d %h %0d dut1 %b%b%b %0d %0d %h %0d required all 0",
               pv0, fs0, lk0, x0, y0, d0, e0, pv1, fs1, lk1, x1, y1, d1, e1);
    else n_pass++;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_nominal();
    send_frame(1'b0, 1'b0, 0, 0, 1'b1, 1);
    send_frame(1'b0, 1'b0, 0, 0, 1'b1, 1);
    send_frame(1'b0, 1'b1, 0, 0, 1'b1, 1);
    send_frame(1'b1, 1'b1, 0, 0, 1'b1, 1);
  endtask

  task automatic relock();
    send_frame(1'b0, 1'b0, 0, 0, 1'b0, 3);
    send_frame(1'b0, 1'b0, 0, 0, 1'b0, 3);
    send_frame(1'b0, 1'b1, 0, 0, 1'b0, 3);
  endtask

  task automatic test_short_line();
    send_frame(1'b1, 1'b1, 1, int'($urandom_range(V_ST + V_ACT - 1, V_ST)), 1'b0, 3);
    relock();
  endtask

  task automatic test_missing_hsync();
    send_frame(1'b1, 1'b1, 2, int'($urandom_range(V_ST + V_ACT - 1, V_ST)), 1'b0, 3);
    relock();
  endtask

  task automatic test_reset_mid();
    send_frame(1'b1, 1'b1, 3, int'($urandom_range(V_ST + V_ACT - 1, V_ST)), 1'b0, 3);
    relock();
    send_frame(1'b1, 1'b1, 0, 0, 1'b1, 2);
  endtask

  task automatic test_polarity();
    n_chk++;
    if (seen0 != pushed || seen1 != pushed)
      $display("FAIL pixel_total: got %0d/%0d required %0d", seen0, seen1, pushed);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_short_line();
    test_missing_hsync();
    test_reset_mid();
    test_polarity();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
